// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//
// Purpose:
//   AXI-Lite initiator for a single client. Each accepted command becomes one
//   AR/R (read) or AW/W/B (write) transaction. An error response is retried
//   with the same address/data up to MAX_RETRY extra times. The final result
//   is returned on a valid/ready response port. Only one transaction is in
//   flight at a time.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             client command handshake (ready in IDLE only)
//   cmd_write, cmd_addr, cmd_wdata  command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready             result handshake
//   rsp_rdata, rsp_ok, rsp_tries    read data (0 for writes), final status,
//                                   issues made minus one (saturates at 3)
//   err_count                       saturating count of every error response
//   ar_*, r_*                       AXI-Lite read address / read data channels
//   aw_*, w_*, b_*                  AXI-Lite write address / data / response
//
// Every output is decoded from the state register or other flops, so there is
// no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MAX_RETRY = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // client command port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_WDTH-1:0] cmd_addr,
  input  logic [DATA_WDTH-1:0] cmd_wdata,
  // client response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  output logic                 rsp_ok,
  output logic [1:0]           rsp_tries,
  output logic [ERR_CNT_W-1:0] err_count,
  // AXI-Lite read address channel
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  // AXI-Lite read data channel
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  // AXI-Lite write address channel
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  // AXI-Lite write data channel
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  // AXI-Lite write response channel
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  // Four state bits leave spare encodings; any of them falls back to IDLE.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_AR_SEND = 4'd1;
  localparam logic [3:0] ST_R_WAIT  = 4'd2;
  localparam logic [3:0] ST_AW_SEND = 4'd3;
  localparam logic [3:0] ST_W_SEND  = 4'd4;
  localparam logic [3:0] ST_B_WAIT  = 4'd5;
  localparam logic [3:0] ST_CHECK   = 4'd6;
  localparam logic [3:0] ST_RESPOND = 4'd7;

  // Retry counter is at least two bits wide so rsp_tries can always be sliced
  // from it, and wide enough to hold MAX_RETRY.
  localparam int RTRY_W = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
  localparam logic [RTRY_W-1:0] MAX_RETRY_V = RTRY_W'(MAX_RETRY);
  localparam logic [RTRY_W-1:0] TRIES_SAT   = RTRY_W'(3);

  logic [3:0]           state_q, state_d;
  logic [ADDR_WDTH-1:0] addr_q,  addr_d;
  logic [DATA_WDTH-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic [DATA_WDTH-1:0] rdata_q, rdata_d;
  logic                 ok_q,    ok_d;
  logic [RTRY_W-1:0]    retry_q, retry_d;
  logic [ERR_CNT_W-1:0] err_q,   err_d;
  // Goes high on the first clock after reset release; keeps cmd_ready low
  // while reset is held even though the state register already reads IDLE.
  logic                 live_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    ok_d    = ok_q;
    retry_d = retry_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && live_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          rdata_d = '0;   // writes report zero read data
          ok_d    = 1'b0;
          retry_d = '0;
          state_d = cmd_write ? ST_AW_SEND : ST_AR_SEND;
        end
      end
      ST_AR_SEND: if (ar_ready) state_d = ST_R_WAIT;
      ST_R_WAIT: begin
        if (r_valid) begin
          rdata_d = r_data;   // kept even on error: failed reads return it
          ok_d    = r_resp[0];
          state_d = ST_CHECK;
        end
      end
      ST_AW_SEND: if (aw_ready) state_d = ST_W_SEND;
      // W is only presented once AW has completed.
      ST_W_SEND:  if (w_ready)  state_d = ST_B_WAIT;
      ST_B_WAIT: begin
        if (b_valid) begin
          ok_d    = b_resp[0];
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ok_q) begin
          state_d = ST_RESPOND;
        end else begin
          if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + 1'b1;
          if (retry_q < MAX_RETRY_V) begin
            retry_d = retry_q + 1'b1;
            state_d = write_q ? ST_AW_SEND : ST_AR_SEND;
          end else begin
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      retry_q <= '0;
      err_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      ok_q    <= ok_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // Output decode. Payloads are gated by their state so a spare encoding
  // drives every channel output to zero.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE) && live_q;
    ar_valid   = (state_q == ST_AR_SEND);
    ar_address = ar_valid ? addr_q : '0;
    r_ready    = (state_q == ST_R_WAIT);
    aw_valid   = (state_q == ST_AW_SEND);
    aw_address = aw_valid ? addr_q : '0;
    w_valid    = (state_q == ST_W_SEND);
    w_data     = w_valid ? wdata_q : '0;
    b_ready    = (state_q == ST_B_WAIT);
    rsp_valid  = (state_q == ST_RESPOND);
    rsp_rdata  = rsp_valid ? rdata_q : '0;
    rsp_ok     = rsp_valid & ok_q;
    rsp_tries  = '0;
    if (rsp_valid) rsp_tries = (retry_q > TRIES_SAT) ? 2'd3 : retry_q[1:0];
    err_count  = err_q;
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//
// Drives client commands into axi_lite_master against a behavioural AXI-Lite
// slave with configurable wait states and error mode. Expected responses are
// queued when a command is accepted and compared when the response is taken.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_ok;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_tries;
  logic [7:0]  err_count;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_address;
  logic [31:0] r_data;
  logic [0:0]  r_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [3:0]  aw_address;
  logic [31:0] w_data;
  logic [0:0]  b_resp;

  axi_lite_master #(
    .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MAX_RETRY(MAXR), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_ok(rsp_ok), .rsp_tries(rsp_tries), .err_count(err_count),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ------------------------------------------------------------ slave config
  bit          err_mode = 1'b0;
  int          ar_delay = 0;
  int          r_delay  = 0;
  int          b_delay  = 0;

  // slave state (written only by the slave process)
  logic [31:0] slv_mem [16];
  int          ar_cnt, aw_cnt, r_cnt, b_cnt;
  int          ar_hs = 0;
  bit          r_pend, b_pend, aw_done, ar_wait;
  logic [3:0]  ar_wait_addr, rd_addr, wr_addr, last_ar_addr, last_aw_addr;
  logic [31:0] wr_data, last_w_data;

  // Decisions are made on the falling edge; a valid/ready pair both high here
  // is a handshake on the following rising edge.
  initial begin
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        r_pend = 0; b_pend = 0; aw_done = 0; ar_wait = 0;
        ar_cnt = 0; aw_cnt = 0; r_cnt = 0; b_cnt = 0;
        continue;
      end
      if (ar_wait) begin
        check_eq("ar_valid_held", ar_valid, 1);
        check_eq("ar_addr_stable", ar_address, ar_wait_addr);
      end
      // read data
      r_valid = 0;
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          r_valid = 1;
          r_resp  = err_mode ? 1'b0 : 1'b1;
          r_data  = err_mode ? (32'hBAD0_0000 | {28'd0, rd_addr}) : slv_mem[rd_addr];
          r_pend  = 0;
        end else r_cnt++;
      end
      // read address
      ar_ready = 0;
      if (ar_valid) begin
        if (ar_cnt >= ar_delay) begin
          ar_ready = 1; ar_cnt = 0; ar_hs++;
          rd_addr = ar_address; last_ar_addr = ar_address;
          r_pend = 1; r_cnt = 0;
        end else ar_cnt++;
      end
      ar_wait      = ar_valid && !ar_ready;
      ar_wait_addr = ar_address;
      // write response
      b_valid = 0;
      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          b_valid = 1;
          b_resp  = err_mode ? 1'b0 : 1'b1;
          if (!err_mode) slv_mem[wr_addr] = wr_data;
          b_pend = 0;
        end else b_cnt++;
      end
      // write data: must follow a completed AW
      w_ready = 0;
      if (w_valid) begin
        check_eq("w_after_aw", aw_done, 1);
        w_ready = 1; wr_data = w_data; last_w_data = w_data;
        aw_done = 0; b_pend = 1; b_cnt = 0;
      end
      // write address
      aw_ready = 0;
      if (aw_valid) begin
        if (aw_cnt >= ar_delay) begin
          aw_ready = 1; aw_cnt = 0;
          wr_addr = aw_address; last_aw_addr = aw_address; aw_done = 1;
        end else aw_cnt++;
      end
    end
  end

  // -------------------------------------------------------------- scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        ok;
    logic [1:0]  tries;
    logic [7:0]  errc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [16];
  int          exp_err = 0;
  int          txn_no  = 0;

  task automatic push_expect(input logic wr, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.ok    = !err_mode;
    e.tries = err_mode ? 2'(MAXR > 3 ? 3 : MAXR) : 2'd0;
    if (err_mode) exp_err = (exp_err + MAXR + 1 > 255) ? 255 : exp_err + MAXR + 1;
    e.errc  = 8'(exp_err);
    if (wr) begin
      e.rdata = '0;
      if (!err_mode) mem_model[a] = d;
    end else begin
      e.rdata = err_mode ? (32'hBAD0_0000 | {28'd0, a}) : mem_model[a];
    end
    sb.push_back(e);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input bit keep);
    int n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("cmd_accept", cmd_ready, 1);
    push_expect(wr, a, d);
    @(negedge clk);
    if (!keep) cmd_valid = 0;
  endtask

  // Waits for a response, holds rsp_ready low for 'hold' cycles, takes it.
  task automatic get_rsp(input int hold, output int wait_n);
    int          n = 0;
    logic [31:0] s_rdata;
    logic        s_ok;
    logic [1:0]  s_tries;
    exp_t        e;
    rsp_ready = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    wait_n = n;
    check_eq("rsp_valid_seen", rsp_valid, 1);
    check_eq("no_bypass", cmd_ready, 0);
    s_rdata = rsp_rdata; s_ok = rsp_ok; s_tries = rsp_tries;
    repeat (hold) begin
      @(negedge clk);
      check_eq("rsp_valid_held", rsp_valid, 1);
      check_eq("rsp_rdata_stable", rsp_rdata, s_rdata);
      check_eq("rsp_ok_stable", rsp_ok, s_ok);
      check_eq("rsp_tries_stable", rsp_tries, s_tries);
    end
    rsp_ready = 1;
    check_eq("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("rsp_rdata", rsp_rdata, e.rdata);
      check_eq("rsp_ok", rsp_ok, e.ok);
      check_eq("rsp_tries", rsp_tries, e.tries);
      check_eq("err_count", err_count, e.errc);
    end
    $display("txn %0d: rdata=0x%08h ok=%0d tries=%0d err_count=%0d wait=%0d",
             txn_no, rsp_rdata, rsp_ok, rsp_tries, err_count, n);
    txn_no++;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int          n, hs0;
    logic [31:0] old_a, d;
    logic [3:0]  a;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; mem_model[i] = '0; end
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_ar_valid", ar_valid, 0);
    check_eq("rst_aw_valid", aw_valid, 0);
    check_eq("rst_w_valid", w_valid, 0);
    check_eq("rst_r_ready", r_ready, 0);
    check_eq("rst_b_ready", b_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_err_count", err_count, 0);
    rst_n = 1;
    @(negedge clk);
    check_eq("idle_cmd_ready", cmd_ready, 1);

    // 1: write 0x3 <- 0xDEADBEEF
    send_cmd(1, 4'h3, 32'hDEADBEEF, 0);
    get_rsp(0, n);
    check_eq("t1_aw_addr", last_aw_addr, 4'h3);
    check_eq("t1_w_data", last_w_data, 32'hDEADBEEF);

    // 2: read 0x3 back, minimum latency
    hs0 = ar_hs;
    send_cmd(0, 4'h3, 0, 0);
    get_rsp(0, n);
    check_eq("t2_latency", n + 1, 4);
    check_eq("t2_ar_addr", last_ar_addr, 4'h3);
    check_eq("t2_ar_count", ar_hs - hs0, 1);

    // 3: error slave, read retried to the limit; then a failing write
    err_mode = 1;
    hs0 = ar_hs;
    send_cmd(0, 4'h5, 0, 0);
    get_rsp(0, n);
    check_eq("t3_ar_count", ar_hs - hs0, MAXR + 1);
    send_cmd(1, 4'h9, 32'h0BAD_CAFE, 0);
    get_rsp(0, n);
    err_mode = 0;

    // 4: slow slave and slow client
    ar_delay = 5; r_delay = 5;
    send_cmd(0, 4'h3, 0, 0);
    get_rsp(3, n);
    ar_delay = 0; r_delay = 0;

    // random write/read pairs (address 0xA reserved for the reset test)
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom_range(0, 8));
      d = $urandom;
      send_cmd(1, a, d, 0);
      get_rsp(i % 2, n);
      send_cmd(0, a, 0, 0);
      get_rsp(0, n);
    end

    // 6: back-to-back with cmd_valid held
    send_cmd(0, 4'h3, 0, 1);
    check_eq("t6_busy", cmd_ready, 0);
    cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'h1234_5678;
    get_rsp(0, n);
    check_eq("t6_ready_after_rsp", cmd_ready, 1);
    send_cmd(1, 4'hC, 32'h1234_5678, 0);
    get_rsp(0, n);
    send_cmd(0, 4'hC, 0, 0);
    get_rsp(0, n);

    // 5: reset while waiting for B
    b_delay = 5;
    old_a = mem_model[4'hA];
    send_cmd(1, 4'hA, 32'h5555_AAAA, 0);
    n = 0;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    check_eq("t5_in_b_wait", b_ready, 1);
    rst_n = 0;
    #1;
    check_eq("t5_b_ready_drop", b_ready, 0);
    check_eq("t5_rsp_valid_drop", rsp_valid, 0);
    check_eq("t5_err_count_clr", err_count, 0);
    sb.delete();
    exp_err = 0;
    mem_model[4'hA] = old_a;
    b_delay = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_eq("t5_post_cmd_ready", cmd_ready, 1);
    check_eq("t5_post_rsp_valid", rsp_valid, 0);
    send_cmd(0, 4'hA, 0, 0);
    get_rsp(0, n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
